vu_meter_led: RTL

- Parametrised LED level-meter driver for the equaliser top level.
- Replaces the fixed 8-LED combinational volume bar with a sequential stereo VU meter: instant-attack/sample-timed-decay level tracking, log-scaled segments, peak-hold dot, and a selectable display mode.
- Includes a volume-pot mode that reproduces the legacy volume bar, generalised to NUM_LEDS.
- Sits beside the equaliser engine and consumes its output samples and the valid strobe.

---
 rtl/vu_pkg.sv | 22 ++
 rtl/vu_level_tracker.sv | 54 +++++
 rtl/vu_meter_led.sv | 97 +++++++++
 3 files changed

// File: rtl/vu_pkg.sv
// Shared types and threshold helpers for the stereo LED level meter.
package vu_pkg;

  typedef enum logic [1:0] {
    VU_BAR  = 2'd0,
    VU_DOT  = 2'd1,
    VU_PEAK = 2'd2,
    VU_VOL  = 2'd3
  } vu_mode_e;

  localparam logic [12:0] VOL_FLOOR = 13'd64;

  // Segment k of n lights at 2^(15-n+k): one doubling (6 dB) per segment.
  function automatic logic [14:0] seg_thr(input int k, input int n);
    return 15'(32'd1 << (15 - n + k));
  endfunction

  function automatic logic [12:0] vol_thr(input int k, input int n);
    return 13'((k * 8192) / n);
  endfunction

endpackage

// File: rtl/vu_level_tracker.sv
// Stereo peak magnitude with instant attack and sample-timed proportional decay.
module vu_level_tracker #(
  parameter int DECAY_SAMPLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [15:0] lft_in,
  input  logic [15:0] rht_in,
  output logic [14:0] lvl,
  output logic [14:0] lvl_next
);

  localparam int DCW = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
  localparam logic [DCW-1:0] DECAY_LAST = DCW'(DECAY_SAMPLES - 1);

  logic [DCW-1:0] decay_cnt_reg, decay_cnt_next;
  logic [14:0]    lvl_reg, lft_mag, rht_mag, mag, decay_step;
  logic           tick;

  // -32768 has no positive twin, so it clips to full scale.
  function automatic logic [14:0] sat_abs(input logic [15:0] x);
    return x[15] ? ((x == 16'h8000) ? 15'h7fff : (~x[14:0] + 15'd1)) : x[14:0];
  endfunction

  always_comb begin
    lft_mag        = sat_abs(lft_in);
    rht_mag        = sat_abs(rht_in);
    mag            = (lft_mag > rht_mag) ? lft_mag : rht_mag;
    tick           = (decay_cnt_reg == DECAY_LAST);
    decay_cnt_next = tick ? '0 : decay_cnt_reg + 1'b1;
    decay_step     = (lvl_reg[14:3] == '0) ? 15'd1 : {3'b000, lvl_reg[14:3]};
    lvl_next       = lvl_reg;
    if (valid) begin
      if (mag > lvl_reg)
        lvl_next = mag;
      else if (tick)
        lvl_next = (lvl_reg == '0) ? '0 : lvl_reg - decay_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decay_cnt_reg <= '0;
      lvl_reg       <= '0;
    end else if (valid) begin
      decay_cnt_reg <= decay_cnt_next;
      lvl_reg       <= lvl_next;
    end
  end

  assign lvl = lvl_reg;

endmodule

// File: rtl/vu_meter_led.sv
// Stereo VU meter LED driver: log bar, dot, bar with peak-hold, and volume-pot bar.
module vu_meter_led
  import vu_pkg::*;
#(
  parameter int NUM_LEDS      = 8,
  parameter int DECAY_SAMPLES = 1024,
  parameter int HOLD_SAMPLES  = 24000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic [15:0]         lft_in,
  input  logic [15:0]         rht_in,
  input  logic [12:0]         vol_in,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] LED
);

  localparam int HCW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_SAMPLES - 1);

  logic [14:0]         lvl, lvl_next;
  logic [NUM_LEDS-1:0] seg_on, seg_on_next, vol_on;
  logic [NUM_LEDS-1:0] bar_mask, dot_mask, peak_mask, vol_mask;
  logic [NUM_LEDS-1:0] led_reg, led_next;
  logic [3:0]          bar_cnt, bar_cnt_next, vcnt, peak_idx_reg;
  logic [HCW-1:0]      hold_cnt_reg;

  vu_level_tracker #(.DECAY_SAMPLES(DECAY_SAMPLES)) u_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (valid),
    .lft_in   (lft_in),
    .rht_in   (rht_in),
    .lvl      (lvl),
    .lvl_next (lvl_next)
  );

  function automatic logic [3:0] count_ones(input logic [NUM_LEDS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Per-segment compares; the peak logic uses the level about to be registered.
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_seg
    assign seg_on[gi]      = (lvl >= seg_thr(gi, NUM_LEDS));
    assign seg_on_next[gi] = (lvl_next >= seg_thr(gi, NUM_LEDS));
    if (gi == 0) begin : g_v0
      assign vol_on[gi] = (vol_in >= VOL_FLOOR);
    end else begin : g_vk
      assign vol_on[gi] = (vol_in >= VOL_FLOOR) && (vol_in > vol_thr(gi, NUM_LEDS));
    end
    assign bar_mask[gi]  = (4'(gi) < bar_cnt);
    assign dot_mask[gi]  = (4'(gi + 1) == bar_cnt);
    assign peak_mask[gi] = (4'(gi + 1) == peak_idx_reg);
    assign vol_mask[gi]  = (4'(gi) < vcnt);
  end

  assign bar_cnt      = count_ones(seg_on);
  assign bar_cnt_next = count_ones(seg_on_next);
  assign vcnt         = count_ones(vol_on);

  always_comb begin
    led_next = '0;
    case (vu_mode_e'(mode))
      VU_BAR:  led_next = bar_mask;
      VU_DOT:  led_next = dot_mask;
      VU_PEAK: led_next = bar_mask | peak_mask;
      VU_VOL:  led_next = vol_mask;
      default: led_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_idx_reg <= '0;
      hold_cnt_reg <= '0;
      led_reg      <= '0;
    end else begin
      led_reg <= led_next;
      if (valid) begin
        if (bar_cnt_next >= peak_idx_reg || hold_cnt_reg == HOLD_LAST) begin
          peak_idx_reg <= bar_cnt_next;
          hold_cnt_reg <= '0;
        end else begin
          hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign LED = led_reg;

endmodule
